// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if -- bundle between the pipeline and its controller.
//   Hazard/status side (core -> controller):
//     loaduse_hazard_i, branch_taken_i, branch_target_i[XLEN],
//     dmem_req_i, dmem_ready_i
//   Control side (controller -> core):
//     pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
//     exmem_stall_o, memwb_flush_o, redirect_valid_o, redirect_pc_o[XLEN],
//     mem_err_o, stall_cnt_o[CNT_W], flush_cnt_o[CNT_W]
//   modport master : the pipeline (drives status, receives strobes)
//   modport slave  : pipe_ctrl
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             loaduse_hazard_i;
    logic             branch_taken_i;
    logic [XLEN-1:0]  branch_target_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;

    logic             pc_stall_o;
    logic             ifid_stall_o;
    logic             ifid_flush_o;
    logic             idex_stall_o;
    logic             idex_flush_o;
    logic             exmem_stall_o;
    logic             memwb_flush_o;
    logic             redirect_valid_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             mem_err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output loaduse_hazard_i, branch_taken_i, branch_target_i,
               dmem_req_i, dmem_ready_i,
        input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
               idex_flush_o, exmem_stall_o, memwb_flush_o,
               redirect_valid_o, redirect_pc_o, mem_err_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  loaduse_hazard_i, branch_taken_i, branch_target_i,
               dmem_req_i, dmem_ready_i,
        output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
               idex_flush_o, exmem_stall_o, memwb_flush_o,
               redirect_valid_o, redirect_pc_o, mem_err_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- stall/flush/redirect controller for the five-stage RV32 core.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : pipe_ctrl_if.slave (hazard/status in, strobes/counters out)
// Strobes are combinational from state and inputs; priority is
// ERR > memory wait > redirect > load-use. A memory-wait watchdog moves the
// FSM to a sticky ERR state; two saturating counters track stall cycles and
// redirects.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    pipe_ctrl_if.slave  bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_ERR} state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic exmem_stall, memwb_flush, redirect_valid;

    logic mem_wait_start;
    assign mem_wait_start = bus.dmem_req_i & ~bus.dmem_ready_i;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // ---------------- next-state logic ----------------
    // wait_cnt counts completed wait cycles; the RUN cycle that starts a wait
    // is the first one, so the counter loads 1 there.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_RUN: begin
                if (mem_wait_start) begin
                    wait_cnt_d = WAIT_W'(1);
                    state_d    = (MEM_TIMEOUT <= 1) ? S_ERR : S_MEMWAIT;
                end
            end
            S_MEMWAIT: begin
                if (bus.dmem_ready_i) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    // This cycle is the MEM_TIMEOUT-th consecutive wait.
                    if (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT - 1))
                        state_d = S_ERR;
                end
            end
            S_ERR: begin
                state_d    = S_ERR;
                wait_cnt_d = wait_cnt_q;
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = '0;
            end
        endcase
        mem_err_d = mem_err_q | (state_d == S_ERR);
    end

    // ---------------- output logic ----------------
    always_comb begin
        pc_stall       = 1'b0;
        ifid_stall     = 1'b0;
        ifid_flush     = 1'b0;
        idex_stall     = 1'b0;
        idex_flush     = 1'b0;
        exmem_stall    = 1'b0;
        memwb_flush    = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            S_RUN: begin
                if (mem_wait_start) begin
                    // Freeze everything upstream of MEM; branch/load-use
                    // inputs are held in the frozen registers for later.
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    memwb_flush = 1'b1;
                end else if (bus.branch_taken_i) begin
                    // ID holds a wrong-path instruction, so a concurrent
                    // load-use hazard is irrelevant.
                    redirect_valid = 1'b1;
                    ifid_flush     = 1'b1;
                    idex_flush     = 1'b1;
                end else if (bus.loaduse_hazard_i) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            S_MEMWAIT: begin
                // The ready cycle lets the pipeline advance with no strobes.
                if (!bus.dmem_ready_i) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    memwb_flush = 1'b1;
                end
            end
            S_ERR: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
            end
            default: begin
                pc_stall = 1'b0;
            end
        endcase
    end

    // ---------------- saturating performance counters ----------------
    // Index 0: stall cycles, index 1: redirects.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_q [2];

    assign cnt_inc = {redirect_valid, pc_stall};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni)
                    cnt_q[gi] <= '0;
                else if (cnt_inc[gi] && (cnt_q[gi] != '1))
                    cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
            end
        end
    endgenerate

    // ---------------- drive the bundle ----------------
    assign bus.pc_stall_o       = pc_stall;
    assign bus.ifid_stall_o     = ifid_stall;
    assign bus.ifid_flush_o     = ifid_flush;
    assign bus.idex_stall_o     = idex_stall;
    assign bus.idex_flush_o     = idex_flush;
    assign bus.exmem_stall_o    = exmem_stall;
    assign bus.memwb_flush_o    = memwb_flush;
    assign bus.redirect_valid_o = redirect_valid;
    assign bus.redirect_pc_o    = redirect_valid ? bus.branch_target_i : '0;
    assign bus.mem_err_o        = mem_err_q;
    assign bus.stall_cnt_o      = cnt_q[0];
    assign bus.flush_cnt_o      = cnt_q[1];
endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- scoreboard bench for pipe_ctrl. The stimulus process drives
// one input set per cycle, computes the expected response from a behavioural
// model (wait length, error flag, counter totals) and queues it; a monitor
// samples the DUT on the falling edge, pops and compares.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;
    localparam int XLEN    = 32;
    localparam int TIMEOUT = 4;
    localparam int CW      = 4;
    localparam int CMAX    = (1 << CW) - 1;

    typedef struct packed {
        logic [6:0]      strb; // pc,ifid_st,ifid_fl,idex_st,idex_fl,exmem_st,memwb_fl
        logic            rv;
        logic [XLEN-1:0] rpc;
        logic            err;
        logic [CW-1:0]   scnt;
        logic [CW-1:0]   fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

    pipe_ctrl #(.XLEN(XLEN), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state
    int   m_wait = 0;     // consecutive memory-wait cycles so far
    bit   m_err  = 0;
    int   m_scnt = 0;
    int   m_fcnt = 0;
    bit   prev_rst_n = 0;
    bit   prev_wait  = 0;
    bit   prev_pcst  = 0;
    bit   prev_rv    = 0;

    task automatic step(input logic rst, input logic ld, input logic br,
                        input logic [XLEN-1:0] tgt, input logic req, input logic rdy);
        exp_t e;
        bit   waiting;
        @(posedge clk);
        // Account for the cycle that just ended.
        if (prev_rst_n) begin
            if (!m_err) begin
                if (prev_wait) begin
                    m_wait++;
                    if (m_wait >= TIMEOUT) m_err = 1;
                end else begin
                    m_wait = 0;
                end
            end
            if (prev_pcst && m_scnt < CMAX) m_scnt++;
            if (prev_rv && m_fcnt < CMAX) m_fcnt++;
        end
        #1;
        if (!rst) begin
            ld = 0; br = 0; tgt = '0; req = 0; rdy = 0;
            m_wait = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
        end
        rst_n                = rst;
        bus.loaduse_hazard_i = ld;
        bus.branch_taken_i   = br;
        bus.branch_target_i  = tgt;
        bus.dmem_req_i       = req;
        bus.dmem_ready_i     = rdy;

        e = '0;
        waiting = 0;
        if (rst) begin
            if (m_err) begin
                e.strb = 7'b1101010;
            end else if (!rdy && (req || m_wait > 0)) begin
                e.strb  = 7'b1101011;
                waiting = 1;
            end else if (m_wait > 0) begin
                e.strb = 7'b0000000;
            end else if (br) begin
                e.strb = 7'b0010100;
                e.rv   = 1'b1;
                e.rpc  = tgt;
            end else if (ld) begin
                e.strb = 7'b1100100;
            end
        end
        e.err  = m_err;
        e.scnt = CW'(m_scnt);
        e.fcnt = CW'(m_fcnt);
        prev_rst_n = rst;
        prev_wait  = waiting;
        prev_pcst  = e.strb[6];
        prev_rv    = e.rv;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0);
    endtask

    // Monitor: compare every cycle that has a queued expectation.
    initial begin
        exp_t e;
        logic [6:0] s;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cyc++;
                s = {bus.pc_stall_o, bus.ifid_stall_o, bus.ifid_flush_o,
                     bus.idex_stall_o, bus.idex_flush_o, bus.exmem_stall_o,
                     bus.memwb_flush_o};
                $display("txn %0d rst_n=%b strb=%b rv=%b pc=%h err=%b scnt=%0d fcnt=%0d",
                         cyc, rst_n, s, bus.redirect_valid_o, bus.redirect_pc_o,
                         bus.mem_err_o, bus.stall_cnt_o, bus.flush_cnt_o);
                checks++;
                if (s !== e.strb) begin
                    errors++;
                    $display("FAIL strobes txn %0d: got %b expected %b", cyc, s, e.strb);
                end
                checks++;
                if (bus.redirect_valid_o !== e.rv || bus.redirect_pc_o !== e.rpc) begin
                    errors++;
                    $display("FAIL redirect txn %0d: got %b/%h expected %b/%h", cyc,
                             bus.redirect_valid_o, bus.redirect_pc_o, e.rv, e.rpc);
                end
                checks++;
                if (bus.mem_err_o !== e.err) begin
                    errors++;
                    $display("FAIL mem_err txn %0d: got %b expected %b", cyc, bus.mem_err_o, e.err);
                end
                checks++;
                if (bus.stall_cnt_o !== e.scnt) begin
                    errors++;
                    $display("FAIL stall_cnt txn %0d: got %0d expected %0d", cyc, bus.stall_cnt_o, e.scnt);
                end
                checks++;
                if (bus.flush_cnt_o !== e.fcnt) begin
                    errors++;
                    $display("FAIL flush_cnt txn %0d: got %0d expected %0d", cyc, bus.flush_cnt_o, e.fcnt);
                end
            end
        end
    end

    initial begin
        logic ld, br, req, rdy;
        logic [XLEN-1:0] tgt;
        bus.loaduse_hazard_i = 0;
        bus.branch_taken_i   = 0;
        bus.branch_target_i  = '0;
        bus.dmem_req_i       = 0;
        bus.dmem_ready_i     = 0;

        do_reset(2);
        idle(2);

        // Load-use pulse: one bubble, stall_cnt becomes 1.
        step(1, 1, 0, '0, 0, 0);
        idle(2);

        // Branch with concurrent load-use hazard.
        step(1, 1, 1, 32'h0000_0100, 0, 0);
        idle(2);

        // Three-cycle memory wait, then ready.
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 1, 0);
        step(1, 0, 0, '0, 1, 1);
        idle(1);

        // Zero-latency memory.
        step(1, 0, 0, '0, 1, 1);
        idle(1);

        // Branch during wait: redirect only after the ready cycle.
        step(1, 0, 0, '0, 1, 0);
        step(1, 0, 1, 32'hDEAD_BEE0, 1, 0);
        step(1, 0, 1, 32'hDEAD_BEE0, 1, 1);
        step(1, 0, 1, 32'hDEAD_BEE0, 0, 0);
        idle(1);

        // Ready on the cycle after TIMEOUT-1 waits: no error.
        for (int i = 0; i < TIMEOUT - 1; i++) step(1, 0, 0, '0, 1, 0);
        step(1, 0, 0, '0, 1, 1);
        idle(1);

        // Timeout: error, sticky, full freeze ignoring later ready.
        for (int i = 0; i < TIMEOUT + 3; i++) step(1, 0, 1, 32'h40, 1, 0);
        step(1, 1, 1, 32'h80, 1, 1);
        idle(2);

        // Reset in the middle of a wait.
        step(1, 0, 0, '0, 1, 0);
        step(1, 0, 0, '0, 1, 0);
        do_reset(2);
        idle(2);

        // Counter saturation.
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, '0, 0, 0);
            step(1, 0, 1, 32'h1000 + XLEN'(i), 0, 0);
        end
        idle(1);
        do_reset(1);

        // Randomised traffic; memory requests stay high while waiting.
        for (int i = 0; i < 400; i++) begin
            ld  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 3) == 0);
            tgt = $urandom;
            req = ($urandom_range(0, 3) == 0) || (m_wait > 0) || prev_wait;
            rdy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0)
                step(0, 0, 0, '0, 0, 0);
            else
                step(1, ld, br, tgt, req, rdy);
        end
        idle(2);

        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
